// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions for the write and read pointer controllers:
// default address width and Gray/binary pointer conversions.
package fifo_pkg;

  localparam int ADDRSIZE_DEF = 9;
  localparam int CONV_W       = 32;

  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
    logic [CONV_W-1:0] b;
    b[CONV_W-1] = g[CONV_W-1];
    for (int i = CONV_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_ctrl_if.sv
// Write-side bundle of the async FIFO: producer request, read pointer from the
// read domain, and the pointer/flag outputs of the write controller.
interface wptr_full_ctrl_if #(
  parameter int ADDRSIZE = fifo_pkg::ADDRSIZE_DEF
) ();

  logic                winc;
  logic [ADDRSIZE:0]   rptr;
  logic                woverflow_clr;
  logic                wen;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic                woverflow;

  modport master (
    output winc, rptr, woverflow_clr,
    input  wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, rptr, woverflow_clr,
    output wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );

endinterface

// File: rtl/wptr_full_ctrl_sync_r2w.sv
// Two-flop synchronizer bringing the Gray read pointer into the write clock
// domain; the only place the read-domain pointer is sampled.
module sync_r2w #(
  parameter int WIDTH = fifo_pkg::ADDRSIZE_DEF + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Async FIFO write-side controller: binary/Gray write pointer, pessimistic full,
// almost-full and fill level against the synchronized read pointer, sticky overflow.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = ADDRSIZE_DEF,
  parameter int AFULL_THRESH = 2**ADDRSIZE - 4
) (
  input  logic          wclk,
  input  logic          wrst,
  wptr_full_ctrl_if.slave bus
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [PW-1:0]     wbin;
  logic [PW-1:0]     wbinnext;
  logic [PW-1:0]     wgraynext;
  logic [PW-1:0]     wq2_rptr;
  logic [PW-1:0]     rbin_sync;
  logic [PW-1:0]     level_next;
  logic [PW-1:0]     wptr_q;
  logic [PW-1:0]     wlevel_q;
  logic              wfull_q;
  logic              walmost_q;
  logic              wovf_q;
  logic              wr_ok;
  logic              full_next;
  logic [CONV_W-1:0] gray_wide;
  logic [CONV_W-1:0] rbin_wide;
  logic              unused_hi;

  sync_r2w #(.WIDTH(PW)) u_sync_r2w (
    .clk (wclk),
    .rst (wrst),
    .d   (bus.rptr),
    .q   (wq2_rptr)
  );

  assign wr_ok     = bus.winc & ~wfull_q;
  assign wbinnext  = wbin + PW'(wr_ok);
  assign gray_wide = bin2gray(CONV_W'(wbinnext));
  assign wgraynext = gray_wide[PW-1:0];
  assign rbin_wide = gray2bin(CONV_W'(wq2_rptr));
  assign rbin_sync = rbin_wide[PW-1:0];

  // Modulo subtraction keeps the level correct across the pointer wrap.
  assign level_next = wbinnext - rbin_sync;
  assign full_next  = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
  assign unused_hi  = ^{gray_wide[CONV_W-1:PW], rbin_wide[CONV_W-1:PW]};

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin      <= '0;
      wptr_q    <= '0;
      wfull_q   <= 1'b0;
      walmost_q <= 1'b0;
      wlevel_q  <= '0;
      wovf_q    <= 1'b0;
    end else begin
      wbin      <= wbinnext;
      wptr_q    <= wgraynext;
      wfull_q   <= full_next;
      walmost_q <= (level_next >= AFULL_LVL);
      wlevel_q  <= level_next;
      // A rejected write wins over a simultaneous clear.
      if (bus.winc && wfull_q) begin
        wovf_q <= 1'b1;
      end else if (bus.woverflow_clr) begin
        wovf_q <= 1'b0;
      end
    end
  end

  assign bus.wen          = wr_ok;
  assign bus.waddr        = wbin[ADDRSIZE-1:0];
  assign bus.wptr         = wptr_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = walmost_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.woverflow    = wovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl at depth 8: directed vector table, wrap sequence at a
// constant level, and random traffic against a counting reference model.
module tb_wptr_full_ctrl;

  localparam int A  = 3;
  localparam int PW = A + 1;
  localparam int AF = 6;

  logic wclk = 1'b0;
  logic wrst;
  always #5 wclk = ~wclk;

  wptr_full_ctrl_if #(.ADDRSIZE(A)) bus ();

  wptr_full_ctrl #(.ADDRSIZE(A), .AFULL_THRESH(AF)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // reference model: counts of items written, read pointer as seen after 2 edges
  int m_wcnt, m_lvl;
  bit m_full, m_af, m_ovf;
  int pipe[$];

  typedef struct {
    bit         rst;
    bit         winc;
    bit         clr;
    logic [3:0] rptr;
    bit         e_wen;
    logic [3:0] e_wptr;
    bit         e_full;
    bit         e_af;
    int         e_lvl;
    bit         e_ovf;
    int         e_addr;
  } vec_t;

  vec_t vt[$];

  function automatic int gray(input int n);
    return (n ^ (n >> 1)) & 15;
  endfunction

  function automatic int ungray(input int g);
    for (int n = 0; n < 16; n++) begin
      if (gray(n) == g) return n;
    end
    return 0;
  endfunction

  function automatic vec_t mk(input bit r, input bit w, input bit c, input logic [3:0] rp,
                              input bit ewen, input logic [3:0] ewp, input bit ef,
                              input bit eaf, input int el, input bit eo, input int ea);
    vec_t v;
    v.rst = r; v.winc = w; v.clr = c; v.rptr = rp;
    v.e_wen = ewen; v.e_wptr = ewp; v.e_full = ef; v.e_af = eaf;
    v.e_lvl = el; v.e_ovf = eo; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit w, input bit c, input logic [3:0] rp);
    wrst              = r;
    bus.winc          = w;
    bus.woverflow_clr = c;
    bus.rptr          = rp;
  endtask

  task automatic model_edge();
    int seen;
    bit do_wr;
    if (wrst) begin
      m_wcnt = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
      pipe = '{0, 0};
    end else begin
      seen = pipe.pop_front();
      pipe.push_back(int'(bus.rptr));
      do_wr = bus.winc && !m_full;
      if (bus.winc && m_full) m_ovf = 1;
      else if (bus.woverflow_clr) m_ovf = 0;
      m_wcnt = (m_wcnt + int'(do_wr)) % 16;
      m_lvl  = (m_wcnt - ungray(seen) + 16) % 16;
      m_full = (m_lvl == 8);
      m_af   = (m_lvl >= AF);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge wclk);
    #1;
  endtask

  logic [3:0] g8 [0:8];
  logic [3:0] prev_wptr;

  initial begin
    int rc;
    bit r, w, c;
    pipe = '{0, 0};
    drive(1'b1, 1'b0, 1'b0, 4'h0);

    g8 = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

    // reset with winc toggling
    vt.push_back(mk(1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, 0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 0));
    // fill to 8 with the reader idle
    for (int k = 1; k <= 8; k++)
      vt.push_back(mk(0, 1, 0, 4'h0, 1, g8[k], k == 8, k >= 6, k, 0, k % 8));
    // overflow, sticky, clear, set-beats-clear, clear
    vt.push_back(mk(0, 1, 0, 4'h0, 0, 4'hC, 1, 1, 8, 1, 0));
    vt.push_back(mk(0, 0, 0, 4'h0, 0, 4'hC, 1, 1, 8, 1, 0));
    vt.push_back(mk(0, 0, 1, 4'h0, 0, 4'hC, 1, 1, 8, 0, 0));
    vt.push_back(mk(0, 1, 1, 4'h0, 0, 4'hC, 1, 1, 8, 1, 0));
    vt.push_back(mk(0, 0, 1, 4'h0, 0, 4'hC, 1, 1, 8, 0, 0));
    // two reads: visible on the third edge
    vt.push_back(mk(0, 0, 0, 4'h3, 0, 4'hC, 1, 1, 8, 0, 0));
    vt.push_back(mk(0, 0, 0, 4'h3, 0, 4'hC, 1, 1, 8, 0, 0));
    vt.push_back(mk(0, 0, 0, 4'h3, 0, 4'hC, 0, 1, 6, 0, 0));
    // refill past the wrap of the address, then overflow again
    vt.push_back(mk(0, 1, 0, 4'h3, 1, 4'hD, 0, 1, 7, 0, 1));
    vt.push_back(mk(0, 1, 0, 4'h3, 1, 4'hF, 1, 1, 8, 0, 2));
    vt.push_back(mk(0, 1, 0, 4'h3, 0, 4'hF, 1, 1, 8, 1, 2));
    // reset mid-operation
    vt.push_back(mk(1, 0, 0, 4'h3, 0, 4'h0, 0, 0, 0, 0, 0));

    foreach (vt[i]) begin
      @(negedge wclk);
      drive(vt[i].rst, vt[i].winc, vt[i].clr, vt[i].rptr);
      #1;
      chk($sformatf("vec%0d wen", i), 32'(bus.wen), 32'(vt[i].e_wen));
      tick();
      chk($sformatf("vec%0d wptr", i), 32'(bus.wptr), 32'(vt[i].e_wptr));
      chk($sformatf("vec%0d wfull", i), 32'(bus.wfull), 32'(vt[i].e_full));
      chk($sformatf("vec%0d walmost_full", i), 32'(bus.walmost_full), 32'(vt[i].e_af));
      chk($sformatf("vec%0d wlevel", i), 32'(bus.wlevel), 32'(vt[i].e_lvl));
      chk($sformatf("vec%0d woverflow", i), 32'(bus.woverflow), 32'(vt[i].e_ovf));
      chk($sformatf("vec%0d waddr", i), 32'(bus.waddr), 32'(vt[i].e_addr));
    end

    // steady writes with the reader trailing at level 3, across the 15->0 wrap
    prev_wptr = bus.wptr;
    for (int n = 1; n <= 23; n++) begin
      @(negedge wclk);
      drive(1'b0, 1'b1, 1'b0, 4'(gray((n - 1) & 15)));
      #1;
      chk($sformatf("wrap%0d wen", n), 32'(bus.wen), 32'd1);
      tick();
      chk($sformatf("wrap%0d wptr", n), 32'(bus.wptr), 32'(gray(n % 16)));
      chk($sformatf("wrap%0d gray_step", n), 32'($countones(bus.wptr ^ prev_wptr)), 32'd1);
      chk($sformatf("wrap%0d wfull", n), 32'(bus.wfull), 32'd0);
      if (n >= 3) chk($sformatf("wrap%0d wlevel", n), 32'(bus.wlevel), 32'd3);
      prev_wptr = bus.wptr;
    end

    // random traffic against the model
    @(negedge wclk);
    drive(1'b1, 1'b0, 1'b0, 4'h0);
    tick();
    rc = 0;
    for (int t = 0; t < 600; t++) begin
      @(negedge wclk);
      r = ($urandom % 64) == 0;
      w = !r && (($urandom % 4) != 0);
      c = ($urandom % 12) == 0;
      if (r) rc = 0;
      else if (((m_wcnt - rc + 16) % 16) > 0 && ($urandom % 3) == 0) rc = (rc + 1) % 16;
      drive(r, w, c, 4'(gray(rc)));
      #1;
      chk($sformatf("rnd%0d wen", t), 32'(bus.wen), 32'(w && !m_full));
      tick();
      chk($sformatf("rnd%0d wptr", t), 32'(bus.wptr), 32'(gray(m_wcnt)));
      chk($sformatf("rnd%0d waddr", t), 32'(bus.waddr), 32'(m_wcnt % 8));
      chk($sformatf("rnd%0d wfull", t), 32'(bus.wfull), 32'(m_full));
      chk($sformatf("rnd%0d walmost_full", t), 32'(bus.walmost_full), 32'(m_af));
      chk($sformatf("rnd%0d wlevel", t), 32'(bus.wlevel), 32'(m_lvl));
      chk($sformatf("rnd%0d woverflow", t), 32'(bus.woverflow), 32'(m_ovf));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wptr_full_ctrl.md
WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 SHALL have parameter ADDRSIZE, 9, address width; FIFO depth = 2**ADDRSIZE.
REQ-002 SHALL have parameter AFULL_THRESH, 2**ADDRSIZE-4, fill level at or above which walmost_full asserts.
REQ-003 SHALL use one clock and a synchronous, active-high reset, sampled on posedge wclk.
REQ-004 wclk  in  1  write-domain clock.
REQ-005 wrst  in  1  synchronous active-high reset.
REQ-006 winc  in  1  write request from the producer.
REQ-007 rptr  in  ADDRSIZE+1  Gray read pointer from the read domain, asynchronous to wclk.
REQ-008 woverflow_clr  in  1  clears the sticky overflow flag.
REQ-009 wen  out  1  memory write enable, = winc & ~wfull, combinational.
REQ-010 waddr  out  ADDRSIZE  memory write address, = wbin[ADDRSIZE-1:0].
REQ-011 wptr  out  ADDRSIZE+1  registered Gray write pointer, sent to the read domain.
REQ-012 wfull  out  1  registered full flag.
REQ-013 walmost_full  out  1  registered almost-full flag.
REQ-014 wlevel  out  ADDRSIZE+1  registered conservative fill level, 0..2**ADDRSIZE.
REQ-015 woverflow  out  1  sticky flag: a write was attempted while full.

Function
REQ-016 Binary pointer: wbinnext = wbin + (winc & ~wfull), modulo 2**(ADDRSIZE+1); wgraynext = (wbinnext>>1) ^ wbinnext; both registered each cycle.
REQ-017 rptr SHALL pass through a 2-flop synchronizer to give wq2_rptr, which is valid 2 wclk edges after rptr changes; no other logic SHALL sample rptr directly.
REQ-018 Full SHALL be computed as wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]} and registered into wfull; it is visible 1 cycle after the write that fills the FIFO.
REQ-019 wq2_rptr SHALL be Gray-to-binary converted; level_next = wbinnext - rbin_sync, an (ADDRSIZE+1)-bit unsigned subtraction that wraps correctly; it is registered into wlevel.
REQ-020 walmost_full SHALL be registered from (level_next >= AFULL_THRESH).
REQ-021 A winc while wfull=1 SHALL NOT advance wbin or wptr, SHALL hold wen at 0, and SHALL set woverflow on the next edge.
REQ-022 woverflow_clr clears woverflow on the next edge; a set and a clear in the same cycle SHALL leave woverflow set.
REQ-023 Since the read pointer seen by this block lags, wfull and wlevel are pessimistic: deassertion SHALL lag a read by up to 3 wclk cycles, and assertion SHALL never lag.
REQ-024 The pointer wrap from 2**(ADDRSIZE+1)-1 to 0 SHALL be seamless, with no false full or level glitch.

Reset
REQ-025 When wrst=1 at posedge wclk, the following SHALL reset on that edge, including mid-operation: wbin=0, wptr=0, both synchronizer stages=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0.
REQ-026 During reset, wen SHALL read winc & ~wfull, i.e. follow winc, because wfull=0; the integrator SHALL hold winc=0 while wrst=1.

Structure
REQ-027 The Gray/binary conversion functions and the default ADDRSIZE SHALL live in a shared package fifo_pkg, shared with the read side.
REQ-028 The synchronizer SHALL be a separate sub-module sync_r2w, parameterised on width, which is the only point where the clock domain is crossed.

Verification
All scenarios use ADDRSIZE=3 (depth 8) and AFULL_THRESH=6.
REQ-029 wrst=1 for 2 cycles with winc toggling -> wptr=0, wfull=0, wlevel=0, woverflow=0, and waddr stays 0.
REQ-030 rptr=0, 8 consecutive winc -> walmost_full=1 after the 6th write, wfull=1 after the 8th, wptr=4'b1100, wlevel=8.
REQ-031 While full, winc=1 for 1 cycle -> wen=0, wptr unchanged at 4'b1100, woverflow=1 and stays 1; then woverflow_clr=1 -> woverflow=0 on the next edge.
REQ-032 While full, drive rptr=4'b0011 (binary 2) -> wfull=0 and wlevel=6 within 3 cycles; walmost_full stays 1.
REQ-033 Perform 20 writes with a read model tracking at level 3 -> the wptr sequence is valid Gray, wlevel stays 3, and wfull never asserts across the wrap 15->0.
REQ-034 Assert woverflow_clr in the same cycle as winc while full -> woverflow=1.
